seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for a bank of DIGITS hexadecimal 7-segment digits.
- Features:
  - Double-buffered value, decimal-point and enable registers.
  - Per-digit blanking.
  - Optional leading-zero suppression.
  - Inter-digit blanking gap to prevent ghosting.
  - Configurable segment and digit polarity.
- Sits between debug/status logic and the board's shared segment bus plus digit-select lines.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_timer.sv | 65 ++++++
 rtl/seg7_scan_driver.sv | 91 +++++++++
 tb/tb_seg7_scan_driver.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment decode for the 7-segment scan driver.
package seg7_pkg;

  typedef enum logic {LIT, GAP} scan_state_t;

  // Bit order gfedcba, 1 = segment lit before polarity is applied.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-content inputs and board-facing segment/digit outputs of the scan driver.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     digit_en;
  logic                  lz_en;
  logic [6:0]            segments;
  logic                  dp_out;
  logic [DIGITS-1:0]     digit_sel;
  logic                  scan_wrap;

  modport master (
    output load, value, dp, digit_en, lz_en,
    input  segments, dp_out, digit_sel, scan_wrap
  );

  modport slave (
    input  load, value, dp, digit_en, lz_en,
    output segments, dp_out, digit_sel, scan_wrap
  );
endinterface

// File: rtl/seg7_scan_timer.sv
// Slot sequencer: REFRESH_DIV lit cycles then BLANK_CYCLES dark cycles per digit.
// idx/lit/scan_wrap are register-derived; scan_wrap marks the cycle idx returns to 0.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx,
  output logic             lit,
  output logic             scan_wrap
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int PRE_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  scan_state_t      state;
  logic [PRE_W-1:0] presc;
  logic             idx_last;

  assign idx_last = (idx == IDX_W'(DIGITS - 1));
  assign lit      = (state == LIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LIT;
      presc     <= '0;
      idx       <= '0;
      scan_wrap <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      case (state)
        LIT: begin
          if (presc == PRE_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            if (BLANK_CYCLES > 0) begin
              state <= GAP;
            end else begin
              idx       <= idx_last ? '0 : idx + 1'b1;
              scan_wrap <= idx_last;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        GAP: begin
          if (presc == PRE_W'(BLANK_CYCLES - 1)) begin
            presc     <= '0;
            state     <= LIT;
            idx       <= idx_last ? '0 : idx + 1'b1;
            scan_wrap <= idx_last;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= LIT;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver with shadowed content, blanking and zero suppression.
// Outputs are registered: shadow updates one edge after load, the display one edge later.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int           IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic         SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic         DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0]   SEG_OFF = {7{SEG_INV}};
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{DIG_INV}};

  logic [DIGITS-1:0][3:0] value_sh;
  logic [DIGITS-1:0]      dp_sh;
  logic [DIGITS-1:0]      en_sh;

  logic [IDX_W-1:0]  idx;
  logic              lit;
  logic              upper_nz;
  logic              zero_sup;
  logic [6:0]        seg_raw;
  logic              dp_raw;
  logic [DIGITS-1:0] sel_raw;

  seg7_scan_timer #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .lit       (lit),
    .scan_wrap (bus.scan_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_sh <= '0;
      dp_sh    <= '0;
      en_sh    <= '1;
    end else if (bus.load) begin
      value_sh <= bus.value;
      dp_sh    <= bus.dp;
      en_sh    <= bus.digit_en;
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && value_sh[i] != 4'h0) upper_nz = 1'b1;
    end
    zero_sup = bus.lz_en && (idx != '0) && !upper_nz;

    seg_raw = '0;
    dp_raw  = 1'b0;
    sel_raw = '0;
    if (lit) begin
      sel_raw = DIGITS'(1) << idx;
      if (en_sh[idx]) begin
        dp_raw = dp_sh[idx];
        if (!zero_sup) seg_raw = hex_to_seg(value_sh[idx]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.segments  <= SEG_OFF;
      bus.dp_out    <= SEG_INV;
      bus.digit_sel <= SEL_OFF;
    end else begin
      bus.segments  <= seg_raw ^ SEG_OFF;
      bus.dp_out    <= dp_raw ^ SEG_INV;
      bus.digit_sel <= sel_raw ^ SEL_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: directed loads push hand-computed per-cycle display states,
// a negedge monitor pops and compares them for two parameterisations.
module tb_seg7_scan_driver;

  typedef struct {
    int         cyc;
    int         tag;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       wrap;
  } exp_t;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SC = 7'b0111001;
  localparam logic [6:0] OFF = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tag_cnt = 0;
  int   r0;
  int   r2;
  exp_t qa[$];
  exp_t qb[$];

  seg7_scan_driver_if #(.DIGITS(4)) bus_a ();
  seg7_scan_driver_if #(.DIGITS(4)) bus_b ();

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s e%0d cycle %0d: got %b, required %b", nm, tag, cyc, act, req);
    end
  endtask

  task automatic check_entry(input string dut, input exp_t e, input logic [3:0] sel,
                             input logic [6:0] seg, input logic dp, input logic wrap);
    if (e.cyc != cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_late e%0d: checked at cycle %0d, required cycle %0d", dut, e.tag, cyc, e.cyc);
    end else begin
      cmp({dut, "_digit_sel"}, e.tag, 32'(sel), 32'(e.sel));
      cmp({dut, "_segments"}, e.tag, 32'(seg), 32'(e.seg));
      cmp({dut, "_dp_out"}, e.tag, 32'(dp), 32'(e.dp));
      cmp({dut, "_scan_wrap"}, e.tag, 32'(wrap), 32'(e.wrap));
    end
  endtask

  task automatic push(input int which, input int c, input logic [3:0] s, input logic [6:0] g,
                      input logic d, input logic w);
    exp_t e;
    e.cyc = c; e.tag = tag_cnt; e.sel = s; e.seg = g; e.dp = d; e.wrap = w;
    tag_cnt++;
    if (which == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Lands 2 time units after the posedge that brings cyc to t.
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      check_entry("a", e, bus_a.digit_sel, bus_a.segments, bus_a.dp_out, bus_a.scan_wrap);
    end
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      check_entry("b", e, bus_b.digit_sel, bus_b.segments, bus_b.dp_out, bus_b.scan_wrap);
    end
  end

  initial begin
    bus_a.load = 1'b0; bus_a.value = '0; bus_a.dp = '0; bus_a.digit_en = '1; bus_a.lz_en = 1'b0;
    bus_b.load = 1'b0; bus_b.value = '0; bus_b.dp = '0; bus_b.digit_en = '1; bus_b.lz_en = 1'b0;

    goto(3);
    rst_n = 1'b1;
    r0 = cyc;
    // A: 4 lit + 1 dark cycle per digit, wrap every 20 cycles.
    push(0, r0,      4'b0000, OFF, 1'b0, 1'b0);
    push(0, r0 + 1,  4'b0001, S0,  1'b0, 1'b0);
    push(0, r0 + 4,  4'b0001, S0,  1'b0, 1'b0);
    push(0, r0 + 5,  4'b0000, OFF, 1'b0, 1'b0);
    push(0, r0 + 6,  4'b0010, S0,  1'b0, 1'b0);
    push(0, r0 + 19, 4'b1000, S0,  1'b0, 1'b0);
    push(0, r0 + 20, 4'b0000, OFF, 1'b0, 1'b1);
    push(0, r0 + 21, 4'b0001, S0,  1'b0, 1'b0);
    push(0, r0 + 40, 4'b0000, OFF, 1'b0, 1'b1);
    // B: inverted polarity, no gap, 4-cycle slots.
    push(1, r0,      4'b1111, 7'b1111111, 1'b1, 1'b0);
    push(1, r0 + 1,  4'b1110, 7'b1000000, 1'b1, 1'b0);
    push(1, r0 + 4,  4'b1110, 7'b1000000, 1'b1, 1'b0);
    push(1, r0 + 5,  4'b1101, 7'b1000000, 1'b1, 1'b0);
    push(1, r0 + 9,  4'b1011, 7'b1000000, 1'b1, 1'b0);
    push(1, r0 + 13, 4'b0111, 7'b1000000, 1'b1, 1'b0);
    push(1, r0 + 16, 4'b0111, 7'b1000000, 1'b1, 1'b1);

    goto(r0 + 12);
    bus_b.load = 1'b1; bus_b.value = 16'h00F7; bus_b.dp = 4'b0001;
    push(1, r0 + 17, 4'b1110, 7'b1111000, 1'b0, 1'b0);
    push(1, r0 + 20, 4'b1110, 7'b1111000, 1'b0, 1'b0);
    push(1, r0 + 21, 4'b1101, 7'b0001110, 1'b1, 1'b0);
    push(1, r0 + 25, 4'b1011, 7'b1000000, 1'b1, 1'b0);
    push(1, r0 + 32, 4'b0111, 7'b1000000, 1'b1, 1'b1);
    goto(r0 + 13);
    bus_b.load = 1'b0;

    goto(r0 + 42);
    bus_a.load = 1'b1; bus_a.value = 16'hA5C0; bus_a.dp = 4'b0100; bus_a.lz_en = 1'b0;
    push(0, r0 + 46, 4'b0010, SC,  1'b0, 1'b0);
    push(0, r0 + 49, 4'b0010, SC,  1'b0, 1'b0);
    push(0, r0 + 50, 4'b0000, OFF, 1'b0, 1'b0);
    push(0, r0 + 51, 4'b0100, S5,  1'b1, 1'b0);
    push(0, r0 + 54, 4'b0100, S5,  1'b1, 1'b0);
    push(0, r0 + 56, 4'b1000, SA,  1'b0, 1'b0);
    push(0, r0 + 59, 4'b1000, SA,  1'b0, 1'b0);
    push(0, r0 + 60, 4'b0000, OFF, 1'b0, 1'b1);
    push(0, r0 + 61, 4'b0001, S0,  1'b0, 1'b0);
    goto(r0 + 43);
    bus_a.load = 1'b0;

    goto(r0 + 62);
    bus_a.load = 1'b1; bus_a.value = 16'h0030; bus_a.dp = 4'b0000; bus_a.lz_en = 1'b1;
    push(0, r0 + 64, 4'b0001, S0,  1'b0, 1'b0);
    push(0, r0 + 66, 4'b0010, S3,  1'b0, 1'b0);
    push(0, r0 + 71, 4'b0100, OFF, 1'b0, 1'b0);
    push(0, r0 + 76, 4'b1000, OFF, 1'b0, 1'b0);
    push(0, r0 + 80, 4'b0000, OFF, 1'b0, 1'b1);
    push(0, r0 + 81, 4'b0001, S0,  1'b0, 1'b0);
    goto(r0 + 63);
    bus_a.load = 1'b0;

    goto(r0 + 82);
    bus_a.load = 1'b1; bus_a.value = 16'h0000; bus_a.dp = 4'b0010;
    push(0, r0 + 86,  4'b0010, OFF, 1'b1, 1'b0);
    push(0, r0 + 91,  4'b0100, OFF, 1'b0, 1'b0);
    push(0, r0 + 96,  4'b1000, OFF, 1'b0, 1'b0);
    push(0, r0 + 101, 4'b0001, S0,  1'b0, 1'b0);
    goto(r0 + 83);
    bus_a.load = 1'b0;

    goto(r0 + 102);
    bus_a.load = 1'b1; bus_a.value = 16'h1234; bus_a.dp = 4'b0001;
    bus_a.digit_en = 4'b1010; bus_a.lz_en = 1'b0;
    push(0, r0 + 104, 4'b0001, OFF, 1'b0, 1'b0);
    push(0, r0 + 106, 4'b0010, S3,  1'b0, 1'b0);
    push(0, r0 + 111, 4'b0100, OFF, 1'b0, 1'b0);
    push(0, r0 + 116, 4'b1000, S1,  1'b0, 1'b0);
    push(0, r0 + 120, 4'b0000, OFF, 1'b0, 1'b1);
    goto(r0 + 103);
    bus_a.load = 1'b0;

    // Load in the middle of digit 1's slot.
    goto(r0 + 126);
    bus_a.load = 1'b1; bus_a.value = 16'h1284;
    push(0, r0 + 126, 4'b0010, S3, 1'b0, 1'b0);
    push(0, r0 + 127, 4'b0010, S3, 1'b0, 1'b0);
    push(0, r0 + 128, 4'b0010, S8, 1'b0, 1'b0);
    push(0, r0 + 129, 4'b0010, S8, 1'b0, 1'b0);
    goto(r0 + 127);
    bus_a.load = 1'b0;

    // Reset during digit 2's slot, then restart from digit 0 with cleared shadow.
    goto(r0 + 132);
    rst_n = 1'b0;
    push(0, r0 + 132, 4'b0000, OFF, 1'b0, 1'b0);
    goto(r0 + 134);
    rst_n = 1'b1;
    r2 = cyc;
    push(0, r2,      4'b0000, OFF, 1'b0, 1'b0);
    push(0, r2 + 1,  4'b0001, S0,  1'b0, 1'b0);
    push(0, r2 + 6,  4'b0010, S0,  1'b0, 1'b0);
    push(0, r2 + 11, 4'b0100, S0,  1'b0, 1'b0);
    push(0, r2 + 16, 4'b1000, S0,  1'b0, 1'b0);
    push(0, r2 + 20, 4'b0000, OFF, 1'b0, 1'b1);

    for (int k = 0; k < 300 && (qa.size() > 0 || qb.size() > 0); k++) @(negedge clk);
    #1;
    while (qa.size() > 0) begin
      exp_t e;
      e = qa.pop_front();
      n_cmp++; n_err++;
      $display("FAIL a_timeout e%0d: never checked, required at cycle %0d", e.tag, e.cyc);
    end
    while (qb.size() > 0) begin
      exp_t e;
      e = qb.pop_front();
      n_cmp++; n_err++;
      $display("FAIL b_timeout e%0d: never checked, required at cycle %0d", e.tag, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
